// File: rtl/vga_pkg.sv
// Shared VGA timing presets and colour-bar definitions for the vga_timing_core slice.
// The bar pattern is only used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam vga_timing_t VGA_800X600  = '{800, 40, 128, 88, 600, 1, 4, 23};
    localparam vga_timing_t VGA_1024X768 = '{1024, 24, 136, 160, 768, 3, 6, 29};

    // One bit per channel {R,G,B}; widened to COLOR_BITS by the consumer.
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // Bar width is H_ACTIVE/8; any remainder falls into the last (black) bar.
    function automatic logic [2:0] bar_rgb(input logic [15:0] x, input int h_active);
        int         bar_w;
        logic [2:0] idx;
        bar_w = (h_active < 8) ? 1 : h_active / 8;
        idx   = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (int'(x) < (i + 1) * bar_w) begin
                idx = 3'(i);
            end
        end
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of configurable width and depth; depth 0 is a wire.
// Reset loads every stage with RESET_VAL so a flushed pipe reads as blanking.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= RESET_VAL;
                end
            end else if (en) begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator with delayed sync/blanking aligned to an external pixel pipe.
// Optional macro VGA_TEST_PATTERN_EN adds a test_mode input selecting 8 vertical colour bars.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_640X480.h_active,
    parameter int H_FP       = VGA_640X480.h_fp,
    parameter int H_SYNC     = VGA_640X480.h_sync,
    parameter int H_BP       = VGA_640X480.h_bp,
    parameter int V_ACTIVE   = VGA_640X480.v_active,
    parameter int V_FP       = VGA_640X480.v_fp,
    parameter int V_SYNC     = VGA_640X480.v_sync,
    parameter int V_BP       = VGA_640X480.v_bp,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_BITS = 4,
    parameter int PIPE_DLY   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    input  logic [3*COLOR_BITS-1:0] color_in,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_active,
    output logic [3*COLOR_BITS-1:0] color_o,
    output logic [15:0]             x_coord,
    output logic [15:0]             y_coord,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_bad_total
        $error("vga_timing_core: H_TOTAL/V_TOTAL exceed 16-bit counter range");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
        $error("vga_timing_core: PIPE_DLY must be within 0..15");
    end

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [16:0] H_ACT_END = 17'(H_ACTIVE);
    localparam logic [16:0] HS_BEG    = 17'(H_ACTIVE + H_FP);
    localparam logic [16:0] HS_END    = 17'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [16:0] V_ACT_END = 17'(V_ACTIVE);
    localparam logic [16:0] VS_BEG    = 17'(V_ACTIVE + V_FP);
    localparam logic [16:0] VS_END    = 17'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic [16:0] h_ext;
    logic [16:0] v_ext;
    logic        hs_raw;
    logic        vs_raw;
    logic        act_raw;
    logic        hs_d;
    logic        vs_d;
    logic        act_d;
    logic [3*COLOR_BITS-1:0] pix_color;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
            end else begin
                h_cnt <= h_cnt + 16'd1;
            end
        end
    end

    assign h_ext   = {1'b0, h_cnt};
    assign v_ext   = {1'b0, v_cnt};
    assign hs_raw  = (h_ext >= HS_BEG && h_ext < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw  = (v_ext >= VS_BEG && v_ext < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    assign act_raw = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);

    assign x_coord = h_cnt;
    assign y_coord = v_cnt;

    // Pulses mark the clock on which the origin coordinate is consumed by an advance.
    assign line_start  = pix_en && !rst && (h_cnt == 16'd0);
    assign frame_start = pix_en && !rst && (h_cnt == 16'd0) && (v_cnt == 16'd0);

    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE_DLY),
        .RESET_VAL({~HSYNC_POL, ~VSYNC_POL, 1'b0})
    ) u_ctrl_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .din ({hs_raw, vs_raw, act_raw}),
        .dout({hs_d, vs_d, act_d})
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [15:0] x_d;
    logic [2:0]  bar;

    // The bar index follows the coordinate that color_in would belong to.
    vga_delay_line #(
        .WIDTH    (16),
        .DEPTH    (PIPE_DLY),
        .RESET_VAL(16'd0)
    ) u_x_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .din (h_cnt),
        .dout(x_d)
    );

    assign bar       = bar_rgb(x_d, H_ACTIVE);
    assign pix_color = test_mode ? {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}}
                                 : color_in;
`else
    assign pix_color = color_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
            video_active <= 1'b0;
            color_o      <= '0;
        end else if (pix_en) begin
            hsync        <= hs_d;
            vsync        <= vs_d;
            video_active <= act_d;
            color_o      <= act_d ? pix_color : '0;
        end
    end

endmodule
